// File: rtl/mdu_arbiter.sv
// mdu_arbiter: shares one multiply/divide unit between two requesters.
// A requester seen in IDLE is acked in the same cycle, and its operands are latched.
// The held operation is then presented to the mdu until the mdu returns a ready pulse.
// The result is routed back to the granted requester with a done pulse.
// When both requesters are pending, a priority pointer alternates between them.
//
// Optional build macro: MDU_ARB_RESULT_REG_EN
//   defined   : o_rd / o_reqn_done are registered (one cycle after i_mdu_ready)
//   undefined : o_rd / o_reqn_done are combinational from i_mdu_ready / i_mdu_rd
//
// state | meaning
// IDLE  | no operation in flight; arbitrate pending requests
// BUSY  | latched operation presented to mdu; waiting for i_mdu_ready

module mdu_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req0_valid,
    input  logic [XLEN-1:0] i_req0_rs1,
    input  logic [XLEN-1:0] i_req0_rs2,
    input  logic [OPW-1:0]  i_req0_op,
    input  logic            i_req1_valid,
    input  logic [XLEN-1:0] i_req1_rs1,
    input  logic [XLEN-1:0] i_req1_rs2,
    input  logic [OPW-1:0]  i_req1_op,
    output logic            o_req0_ack,
    output logic            o_req1_ack,
    output logic            o_req0_done,
    output logic            o_req1_done,
    output logic [XLEN-1:0] o_rd,
    output logic            o_busy,
    output logic [XLEN-1:0] o_mdu_rs1,
    output logic [XLEN-1:0] o_mdu_rs2,
    output logic [OPW-1:0]  o_mdu_op,
    output logic            o_mdu_valid,
    input  logic            i_mdu_ready,
    input  logic [XLEN-1:0] i_mdu_rd
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            prio_q, prio_d;     // 0: requester 0 wins a tie, 1: requester 1 wins
    logic            grant_q, grant_d;   // id of the requester owning the mdu
    logic [XLEN-1:0] rs1_q, rs2_q;
    logic [OPW-1:0]  op_q;
    logic            gnt0, gnt1;
    logic            cpl;
    logic            in_busy;

    // State, arbitration bookkeeping and operand capture at grant time.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            grant_q <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            grant_q <= grant_d;
            if (gnt0) begin
                rs1_q <= i_req0_rs1;
                rs2_q <= i_req0_rs2;
                op_q  <= i_req0_op;
            end else if (gnt1) begin
                rs1_q <= i_req1_rs1;
                rs2_q <= i_req1_rs2;
                op_q  <= i_req1_op;
            end
        end
    end

    // Next-state, grant selection and completion detection.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        grant_d     = grant_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        cpl         = 1'b0;
        o_mdu_valid = 1'b0;
        o_busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req0_valid && (!i_req1_valid || !prio_q)) begin
                    gnt0    = 1'b1;
                    grant_d = 1'b0;
                    state_d = BUSY;
                end else if (i_req1_valid) begin
                    gnt1    = 1'b1;
                    grant_d = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                o_mdu_valid = 1'b1;
                o_busy      = 1'b1;
                // A completion coinciding with reset belongs to an aborted operation.
                if (i_mdu_ready && !i_rst) begin
                    cpl     = 1'b1;
                    prio_d  = ~grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_busy    = (state_q == BUSY);
    assign o_req0_ack = gnt0;
    assign o_req1_ack = gnt1;

    // Operands are shown only while the request is live, so the mdu bus reads zero in IDLE.
    assign o_mdu_rs1  = in_busy ? rs1_q : '0;
    assign o_mdu_rs2  = in_busy ? rs2_q : '0;
    assign o_mdu_op   = in_busy ? op_q  : '0;

`ifdef MDU_ARB_RESULT_REG_EN
    logic            done0_q, done1_q;
    logic [XLEN-1:0] rd_q;

    // Result return pipelined by one cycle; the FSM is already back in IDLE meanwhile.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            done0_q <= cpl & ~grant_q;
            done1_q <= cpl &  grant_q;
            rd_q    <= cpl ? i_mdu_rd : '0;
        end
    end

    assign o_req0_done = done0_q;
    assign o_req1_done = done1_q;
    assign o_rd        = rd_q;
`else
    assign o_req0_done = cpl & ~grant_q;
    assign o_req1_done = cpl &  grant_q;
    assign o_rd        = cpl ? i_mdu_rd : '0;
`endif

endmodule

// File: doc/mdu_arbiter.md
MDU_ARBITER -- requirements
Module: mdu_arbiter

Interface
REQ-001 Parameter XLEN, default 32, operand and result width.
REQ-002 Parameter OPW, default 3, MDU opcode width.
REQ-003 i_clk  input  1  single clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_req0_valid / i_req1_valid  input  1  requester n has an operation pending.
REQ-006 i_req0_rs1, i_req0_rs2 / i_req1_rs1, i_req1_rs2  input  XLEN  operands of requester n.
REQ-007 i_req0_op / i_req1_op  input  OPW  MDU opcode of requester n.
REQ-008 o_req0_ack / o_req1_ack  output  1  one-cycle pulse: request n latched.
REQ-009 o_req0_done / o_req1_done  output  1  one-cycle pulse: result for requester n on o_rd.
REQ-010 o_rd  output  XLEN  shared result bus, qualified by o_reqn_done.
REQ-011 o_busy  output  1  high while an operation is in flight.
REQ-012 o_mdu_rs1, o_mdu_rs2  output  XLEN  operands to mdu.
REQ-013 o_mdu_op  output  OPW  opcode to mdu.
REQ-014 o_mdu_valid  output  1  operation request to mdu.
REQ-015 i_mdu_ready  input  1  mdu completion pulse.
REQ-016 i_mdu_rd  input  XLEN  mdu result, valid with i_mdu_ready.

Function
REQ-017 FSM states: IDLE, BUSY.
REQ-018 IDLE, no i_reqn_valid: stay IDLE, o_mdu_valid=0.
REQ-019 IDLE, one requester valid: latch its rs1/rs2/op into operand registers, pulse its o_reqn_ack, record grant id, go BUSY next cycle.
REQ-020 IDLE, both valid: grant requester selected by priority pointer; the other gets no ack and stays pending.
REQ-021 BUSY: o_mdu_valid=1, o_mdu_rs1/rs2/op driven from latched registers, held stable until i_mdu_ready.
REQ-022 BUSY with i_mdu_ready=1: o_rd=i_mdu_rd, pulse o_reqn_done for granted id in the same cycle, set priority pointer to the non-granted requester, go IDLE.
REQ-023 Issue latency: ack in the cycle req is seen in IDLE; o_mdu_valid rises the next cycle.
REQ-024 Minimum one IDLE cycle between completion and next grant.
REQ-025 i_mdu_ready while IDLE is ignored: no done pulse, no state change.
REQ-026 Requester input changes while BUSY do not affect latched operands.
REQ-027 Requester deasserts valid before ack: no grant, no side effect.
REQ-028 o_busy=1 exactly in BUSY; o_rd=0 in any cycle without a done pulse.
REQ-029 At most one ack and at most one done pulse per cycle.

Reset
REQ-030 i_rst sampled high: state IDLE, priority pointer=requester 0, grant id=0, operand registers=0.
REQ-031 Reset outputs: o_mdu_valid=0, o_busy=0, all ack/done=0, o_rd=0, o_mdu_rs1/rs2/op=0.
REQ-032 Reset during BUSY aborts the operation; no done pulse is ever issued for it; mdu is reset in parallel.

Configuration
REQ-033 Macro MDU_ARB_RESULT_REG_EN defined: o_rd and o_reqn_done are registered, appearing one cycle after i_mdu_ready; return to IDLE is unchanged.
REQ-034 Macro undefined: o_rd and o_reqn_done are combinational from i_mdu_ready/i_mdu_rd as REQ-022.

Verification
REQ-035 Reset, then req0 rs1=6 rs2=7 op=0 -> ack0 same cycle, o_mdu_valid next cycle; mdu ready with rd=42 -> done0=1, o_rd=42, done1=0.
REQ-036 req0 and req1 both valid from reset -> req0 granted first; after completion req1 granted; after req1 completion both pending again -> req0 granted (alternation).
REQ-037 req1 changes rs1 from 5 to 9 while BUSY -> o_mdu_rs1 stays 5 until i_mdu_ready.
REQ-038 i_mdu_ready pulsed in IDLE with rd=0xDEAD -> no done pulse, o_rd=0, state IDLE.
REQ-039 i_rst asserted 3 cycles into BUSY -> o_mdu_valid=0, o_busy=0 next cycle; no done pulse afterwards; next grant goes to req0.
REQ-040 With MDU_ARB_RESULT_REG_EN: rd=100 on i_mdu_ready -> done and o_rd=100 exactly one cycle later.
